// File: rtl/warp_issue_arbiter_pkg.sv
// Shared warp-scheduling definitions: default warp count, per-warp lifecycle
// encoding and warp-id width derivation.
package warp_issue_arbiter_pkg;

  localparam int unsigned DEFAULT_NUM_WARPS   = 4;
  localparam int unsigned DEFAULT_STALL_WIDTH = 4;

  typedef enum logic [1:0] {
    WARP_IDLE    = 2'd0,
    WARP_READY   = 2'd1,
    WARP_STALLED = 2'd2,
    WARP_DONE    = 2'd3
  } warp_state_t;

  function automatic int unsigned warp_id_width(input int unsigned num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  localparam int unsigned DEFAULT_WARP_ID_WIDTH = warp_id_width(DEFAULT_NUM_WARPS);

endpackage

// File: rtl/warp_issue_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first eligible warp at or after the
// start pointer, wrapping modulo NUM_WARPS.
module rr_priority_pick
  import warp_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_WARPS     = DEFAULT_NUM_WARPS,
  parameter int unsigned WARP_ID_WIDTH = warp_id_width(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0]     eligible,
  input  logic [WARP_ID_WIDTH-1:0] start,
  output logic                     found,
  output logic [WARP_ID_WIDTH-1:0] pick
);

  logic [WARP_ID_WIDTH-1:0] idx;

  always_comb begin
    found = 1'b0;
    pick  = start;
    idx   = start;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      // Width-limited add wraps naturally since NUM_WARPS is a power of two.
      idx = start + WARP_ID_WIDTH'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/warp_issue_arbiter.sv
// Per-warp lifecycle tracking plus a registered round-robin issue offer
// toward fetch with a valid/ready handshake.
module warp_issue_arbiter
  import warp_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_WARPS     = DEFAULT_NUM_WARPS,
  parameter int unsigned WARP_ID_WIDTH = warp_id_width(NUM_WARPS),
  parameter int unsigned STALL_WIDTH   = DEFAULT_STALL_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WARPS-1:0]     warp_launch,
  input  logic                     issue_ready,
  input  logic                     stall_req,
  input  logic [WARP_ID_WIDTH-1:0] stall_warp,
  input  logic [STALL_WIDTH-1:0]   stall_cycles,
  input  logic                     done_req,
  input  logic [WARP_ID_WIDTH-1:0] done_warp,
  output logic [WARP_ID_WIDTH-1:0] select_warp,
  output logic                     issue_valid,
  output logic [NUM_WARPS-1:0]     pc_advance,
  output logic                     all_done
);

  logic [NUM_WARPS-1:0]     eligible;
  logic [NUM_WARPS-1:0]     busy_next;
  logic [NUM_WARPS-1:0]     done_next;
  logic                     accept;
  logic                     rearbitrate;
  logic                     found;
  logic [WARP_ID_WIDTH-1:0] rr_ptr;
  logic [WARP_ID_WIDTH-1:0] search_start;
  logic [WARP_ID_WIDTH-1:0] pick;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    warp_state_t            state, state_next;
    logic [STALL_WIDTH-1:0] count, count_next;
    logic                   stall_hit, done_hit, last_stall_cycle;

    assign stall_hit = stall_req && (stall_warp == WARP_ID_WIDTH'(g)) && (stall_cycles != '0);
    assign done_hit  = done_req && (done_warp == WARP_ID_WIDTH'(g));
    // The final stall cycle already arbitrates, so a stall of N seen at edge k
    // can be re-offered right after edge k+N.
    assign last_stall_cycle = (state == WARP_STALLED) && (count == STALL_WIDTH'(1));

    always_comb begin
      state_next = state;
      count_next = count;
      case (state)
        WARP_IDLE, WARP_DONE: begin
          if (warp_launch[g]) state_next = WARP_READY;
        end
        WARP_READY: begin
          if (done_hit) begin
            state_next = WARP_DONE;
          end else if (stall_hit) begin
            state_next = WARP_STALLED;
            count_next = stall_cycles;
          end
        end
        WARP_STALLED: begin
          if (done_hit) begin
            state_next = WARP_DONE;
            count_next = '0;
          end else if (stall_hit) begin
            count_next = stall_cycles;
          end else if (count == STALL_WIDTH'(1)) begin
            state_next = WARP_READY;
            count_next = '0;
          end else begin
            count_next = count - STALL_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        state <= WARP_IDLE;
        count <= '0;
      end else begin
        state <= state_next;
        count <= count_next;
      end
    end

    assign eligible[g]  = ((state == WARP_READY) || last_stall_cycle) && !stall_hit && !done_hit;
    assign busy_next[g] = (state_next == WARP_READY) || (state_next == WARP_STALLED);
    assign done_next[g] = (state_next == WARP_DONE);
  end

  assign accept       = issue_valid && issue_ready;
  assign pc_advance   = accept ? ({{(NUM_WARPS-1){1'b0}}, 1'b1} << select_warp) : '0;
  // Withdrawal of a stalled/done offer falls into the same search as no offer.
  assign rearbitrate  = !issue_valid || accept || !eligible[select_warp];
  assign search_start = accept ? (select_warp + WARP_ID_WIDTH'(1)) : rr_ptr;

  rr_priority_pick #(
    .NUM_WARPS    (NUM_WARPS),
    .WARP_ID_WIDTH(WARP_ID_WIDTH)
  ) u_pick (
    .eligible(eligible),
    .start   (search_start),
    .found   (found),
    .pick    (pick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr      <= '0;
      select_warp <= '0;
      issue_valid <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      if (accept) rr_ptr <= search_start;
      if (rearbitrate) begin
        issue_valid <= found;
        if (found) select_warp <= pick;
      end
      all_done <= !(|busy_next) && (|done_next);
    end
  end

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Bench for warp_issue_arbiter: directed scenarios plus random traffic, all
// compared against a release-time based behavioural model of the warps.
module tb_warp_issue_arbiter;

  localparam int NW = 4;
  localparam int S_IDLE = 0, S_READY = 1, S_STALLED = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] warp_launch;
  logic       issue_ready;
  logic       stall_req;
  logic [1:0] stall_warp;
  logic [3:0] stall_cycles;
  logic       done_req;
  logic [1:0] done_warp;
  logic [1:0] select_warp;
  logic       issue_valid;
  logic [3:0] pc_advance;
  logic       all_done;

  warp_issue_arbiter #(
    .NUM_WARPS    (4),
    .WARP_ID_WIDTH(2),
    .STALL_WIDTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .warp_launch (warp_launch),
    .issue_ready (issue_ready),
    .stall_req   (stall_req),
    .stall_warp  (stall_warp),
    .stall_cycles(stall_cycles),
    .done_req    (done_req),
    .done_warp   (done_warp),
    .select_warp (select_warp),
    .issue_valid (issue_valid),
    .pc_advance  (pc_advance),
    .all_done    (all_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: warp status plus the edge number at which a stalled warp may arbitrate again.
  int mst [NW];
  int rel [NW];
  bit mv;
  int msel;
  int mrr;
  bit mad;
  int edge_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit el [NW];
    bit acc, found;
    int start, pick;
    edge_n++;
    if (!reset) begin
      for (int i = 0; i < NW; i++) begin mst[i] = S_IDLE; rel[i] = 0; end
      mv = 0; msel = 0; mrr = 0; mad = 0;
      return;
    end
    for (int i = 0; i < NW; i++) begin
      bit st_t, dn_t;
      st_t = stall_req && (stall_cycles != 0) && (int'(stall_warp) == i);
      dn_t = done_req && (int'(done_warp) == i);
      el[i] = (mst[i] == S_READY || (mst[i] == S_STALLED && edge_n >= rel[i])) && !st_t && !dn_t;
    end
    acc = mv && issue_ready;
    if (!mv || acc || !el[msel]) begin
      start = acc ? (msel + 1) % NW : mrr;
      if (acc) mrr = start;
      found = 0; pick = 0;
      for (int j = 0; j < NW; j++) begin
        int c;
        c = (start + j) % NW;
        if (!found && el[c]) begin found = 1; pick = c; end
      end
      mv = found;
      if (found) msel = pick;
    end
    for (int i = 0; i < NW; i++) begin
      bit st_t, dn_t;
      st_t = stall_req && (stall_cycles != 0) && (int'(stall_warp) == i);
      dn_t = done_req && (int'(done_warp) == i);
      case (mst[i])
        S_IDLE, S_DONE: if (warp_launch[i]) mst[i] = S_READY;
        S_READY: begin
          if (dn_t) mst[i] = S_DONE;
          else if (st_t) begin mst[i] = S_STALLED; rel[i] = edge_n + int'(stall_cycles); end
        end
        default: begin
          if (dn_t) mst[i] = S_DONE;
          else if (st_t) rel[i] = edge_n + int'(stall_cycles);
          else if (edge_n >= rel[i]) mst[i] = S_READY;
        end
      endcase
    end
    begin
      bit any_busy, any_done;
      any_busy = 0; any_done = 0;
      for (int i = 0; i < NW; i++) begin
        if (mst[i] == S_READY || mst[i] == S_STALLED) any_busy = 1;
        if (mst[i] == S_DONE) any_done = 1;
      end
      mad = !any_busy && any_done;
    end
  endtask

  // One clock: check pc_advance before the edge, step the model, check registers after.
  task automatic cycle();
    logic [3:0] exp_pc;
    #1;
    if (edge_n > 0) begin
      exp_pc = (mv && issue_ready) ? 4'(1 << msel) : 4'b0000;
      chk("pc_advance", 32'(pc_advance), 32'(exp_pc));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("issue_valid", 32'(issue_valid), 32'(mv));
    if (mv) chk("select_warp", 32'(select_warp), 32'(msel));
    chk("all_done", 32'(all_done), 32'(mad));
  endtask

  task automatic idle_inputs();
    warp_launch  = '0;
    issue_ready  = 1'b0;
    stall_req    = 1'b0;
    stall_warp   = '0;
    stall_cycles = '0;
    done_req     = 1'b0;
    done_warp    = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [3:0] tp1_seq [5];
    bit reached;
    tp1_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset
    idle_inputs();
    reset = 1'b0;
    cycle();
    cycle();
    chk("rst_outputs", 32'({select_warp, issue_valid, all_done, pc_advance}), 32'd0);
    reset = 1'b1;

    // Launch all, back-to-back round robin
    warp_launch = 4'b1111;
    issue_ready = 1'b1;
    cycle();
    chk("tp1_no_offer_yet", 32'(issue_valid), 32'd0);
    warp_launch = '0;
    cycle();
    chk("tp1_first_valid", 32'(issue_valid), 32'd1);
    for (int j = 0; j < 5; j++) begin
      chk("tp1_pc_seq", 32'(pc_advance), 32'(tp1_seq[j]));
      cycle();
    end

    // Hold an offer of warp 2 while fetch is not ready
    cycle();
    chk("tp2_offer2", 32'(select_warp), 32'd2);
    issue_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("tp2_hold_pc", 32'(pc_advance), 32'd0);
      cycle();
      chk("tp2_hold_sel", 32'(select_warp), 32'd2);
      chk("tp2_hold_valid", 32'(issue_valid), 32'd1);
    end
    issue_ready = 1'b1;
    #1;
    chk("tp2_accept_pc", 32'(pc_advance), 32'b0100);
    cycle();
    chk("tp2_next3", 32'(select_warp), 32'd3);

    // Finish warps 2,3; stall warp 1 for 3 cycles
    issue_ready = 1'b0;
    done_req = 1'b1; done_warp = 2'd2;
    cycle();
    done_warp = 2'd3;
    cycle();
    done_req = 1'b0;
    issue_ready = 1'b1;
    stall_req = 1'b1; stall_warp = 2'd1; stall_cycles = 4'd3;
    cycle();
    stall_req = 1'b0;
    chk("tp3_k_sel0", 32'({issue_valid, select_warp}), 32'b100);
    cycle();
    chk("tp3_k1_sel0", 32'({issue_valid, select_warp}), 32'b100);
    cycle();
    chk("tp3_k2_sel0", 32'({issue_valid, select_warp}), 32'b100);
    cycle();
    chk("tp3_k3_sel1", 32'({issue_valid, select_warp}), 32'b101);

    // done beats stall; all_done; relaunch
    issue_ready = 1'b0;
    stall_req = 1'b1; stall_warp = 2'd0; stall_cycles = 4'd2;
    done_req = 1'b1; done_warp = 2'd0;
    cycle();
    stall_req = 1'b0;
    chk("tp4_not_all_done", 32'(all_done), 32'd0);
    done_warp = 2'd1;
    cycle();
    done_req = 1'b0;
    chk("tp4_all_done", 32'(all_done), 32'd1);
    chk("tp4_no_offer", 32'(issue_valid), 32'd0);
    warp_launch = 4'b0001;
    cycle();
    warp_launch = '0;
    chk("tp4_relaunch_clear", 32'(all_done), 32'd0);
    cycle();
    chk("tp4_offer0", 32'({issue_valid, select_warp}), 32'b100);

    // Accept warp 1 while it is stalled in the same cycle
    warp_launch = 4'b0110;
    cycle();
    warp_launch = '0;
    issue_ready = 1'b1;
    reached = 0;
    for (int j = 0; j < 8 && !reached; j++) begin
      if (issue_valid && select_warp == 2'd1) reached = 1;
      else cycle();
    end
    chk("tp5_reach_offer1", 32'(reached), 32'd1);
    stall_req = 1'b1; stall_warp = 2'd1; stall_cycles = 4'd2;
    #1;
    chk("tp5_accept_pc", 32'(pc_advance), 32'b0010);
    cycle();
    stall_req = 1'b0;
    chk("tp5_not1_a", 32'(issue_valid && select_warp == 2'd1), 32'd0);
    cycle();
    chk("tp5_not1_b", 32'(issue_valid && select_warp == 2'd1), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 63) != 0);
      warp_launch  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      issue_ready  = ($urandom_range(0, 3) != 0);
      stall_req    = ($urandom_range(0, 3) == 0);
      stall_warp   = 2'($urandom);
      stall_cycles = 4'($urandom_range(0, 6));
      done_req     = ($urandom_range(0, 7) == 0);
      done_warp    = 2'($urandom);
      cycle();
    end

    // Reset while a warp is stalled and an offer is pending
    idle_inputs();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    warp_launch = 4'b1111;
    cycle();
    warp_launch = '0;
    cycle();
    stall_req = 1'b1; stall_warp = 2'd2; stall_cycles = 4'd10;
    cycle();
    stall_req = 1'b0;
    chk("tp6_pending", 32'(issue_valid), 32'd1);
    reset = 1'b0;
    cycle();
    chk("tp6_rst_outputs", 32'({select_warp, issue_valid, all_done, pc_advance}), 32'd0);
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("tp6_no_offer", 32'(issue_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
